// File: rtl/data_inf_stream_pkg.sv
// Shared types and helpers for the data_inf stream traffic source.
// Holds the FSM state encoding, payload mode codes and the Galois LFSR step.
package data_inf_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        FINISH
    } src_state_e;

    localparam logic MODE_INC  = 1'b0;
    localparam logic MODE_LFSR = 1'b1;

    // Widest payload the LFSR helper handles; callers zero-extend and truncate.
    localparam int LFSR_MAX_W = 64;

    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] d,
        input logic [LFSR_MAX_W-1:0] taps
    );
        return (d >> 1) ^ (d[0] ? taps : '0);
    endfunction

endpackage

// File: rtl/data_inf_stream_src.sv
// Frame traffic source on a valid/ready link: first beat one cycle after start, one beat/cycle.
// Outputs are registered; m_valid never waits on m_ready and data/last hold while stalled.
module data_inf_stream_src
    import data_inf_stream_pkg::*;
#(
    parameter int               DSIZE = 8,
    parameter int               LSIZE = 16,
    parameter int               GSIZE = 8,
    parameter logic [DSIZE-1:0] TAPS  = DSIZE'(8'hB8)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start,
    input  logic             mode,
    input  logic [DSIZE-1:0] seed,
    input  logic [LSIZE-1:0] frame_len,
    input  logic [LSIZE-1:0] frame_cnt,
    input  logic [GSIZE-1:0] gap_len,
    output logic             busy,
    output logic             done,
    output logic [LSIZE-1:0] frames_sent,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic             m_last
);

    src_state_e       state_q, state_d;
    logic             mode_q, mode_d;
    logic [LSIZE-1:0] len_q, len_d;
    logic [LSIZE-1:0] cnt_q, cnt_d;
    logic [GSIZE-1:0] gap_len_q, gap_len_d;
    logic [LSIZE-1:0] beat_q, beat_d;
    logic [LSIZE-1:0] frames_q, frames_d;
    logic [GSIZE-1:0] gap_q, gap_d;
    logic [DSIZE-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             xfer;
    logic [LSIZE-1:0] frames_inc;
    logic [LSIZE-1:0] beat_inc;
    logic [LSIZE-1:0] len_last;
    logic [DSIZE-1:0] data_next;

    assign xfer       = valid_q && m_ready;
    assign frames_inc = frames_q + LSIZE'(1);
    assign beat_inc   = beat_q + LSIZE'(1);
    assign len_last   = len_q - LSIZE'(1);
    assign data_next  = (mode_q == MODE_LFSR)
                      ? DSIZE'(lfsr_next(LFSR_MAX_W'(data_q), LFSR_MAX_W'(TAPS)))
                      : data_q + DSIZE'(1);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        gap_len_d = gap_len_q;
        beat_d    = beat_q;
        frames_d  = frames_q;
        gap_d     = gap_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    frames_d = '0;
                    if (frame_len == '0 || frame_cnt == '0) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = SEND;
                        mode_d    = mode;
                        len_d     = frame_len;
                        cnt_d     = frame_cnt;
                        gap_len_d = gap_len;
                        beat_d    = '0;
                        valid_d   = 1'b1;
                        busy_d    = 1'b1;
                        last_d    = (frame_len == LSIZE'(1));
                        // An all-zero LFSR state would lock up, so it is nudged to 1.
                        if (mode == MODE_LFSR && seed == '0) begin
                            data_d = DSIZE'(1);
                        end else begin
                            data_d = seed;
                        end
                    end
                end
            end

            SEND: begin
                if (xfer) begin
                    if (last_q) begin
                        frames_d = frames_inc;
                        beat_d   = '0;
                        if (frames_inc == cnt_q) begin
                            state_d = FINISH;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else if (gap_len_q != '0) begin
                            state_d = GAP;
                            gap_d   = gap_len_q - GSIZE'(1);
                            data_d  = data_next;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                        end else begin
                            data_d = data_next;
                            last_d = (len_last == '0);
                        end
                    end else begin
                        beat_d = beat_inc;
                        data_d = data_next;
                        last_d = (beat_inc == len_last);
                    end
                end
            end

            GAP: begin
                // gap_q counts the idle cycles still owed after this one.
                if (gap_q == '0) begin
                    state_d = SEND;
                    valid_d = 1'b1;
                    last_d  = (len_last == '0);
                end else begin
                    gap_d = gap_q - GSIZE'(1);
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            mode_q    <= MODE_INC;
            len_q     <= '0;
            cnt_q     <= '0;
            gap_len_q <= '0;
            beat_q    <= '0;
            frames_q  <= '0;
            gap_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            gap_len_q <= gap_len_d;
            beat_q    <= beat_d;
            frames_q  <= frames_d;
            gap_q     <= gap_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign frames_sent = frames_q;
    assign m_valid     = valid_q;
    assign m_data      = data_q;
    assign m_last      = last_q;

endmodule

// File: tb/tb_data_inf_stream_src.sv
// Randomised scoreboard bench for data_inf_stream_src: a frame-level model queues
// expected beats, gaps and done events; an independent monitor checks them off.
module tb_data_inf_stream_src;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start;
    logic        mode;
    logic [7:0]  seed;
    logic [15:0] frame_len;
    logic [15:0] frame_cnt;
    logic [7:0]  gap_len;
    logic        busy;
    logic        done;
    logic [15:0] frames_sent;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_last;

    data_inf_stream_src #(
        .DSIZE(8), .LSIZE(16), .GSIZE(8), .TAPS(8'hB8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start(start), .mode(mode), .seed(seed),
        .frame_len(frame_len), .frame_cnt(frame_cnt), .gap_len(gap_len),
        .busy(busy), .done(done), .frames_sent(frames_sent),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic       f;
    } beat_t;

    beat_t exp_beats[$];
    int    exp_gaps[$];
    int    exp_done[$];

    int checks = 0;
    int errors = 0;
    int ready_pct = 100;
    int xfer_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic bad(input string name);
        checks++;
        errors++;
        $display("FAIL %s (no expectation for this event) at %0t", name, $time);
    endtask

    // Reference: whole run expanded into the beat stream the link should carry.
    task automatic model_push(input bit m, input logic [7:0] s, input int len,
                              input int cnt, input int gap);
        logic [7:0] d;
        beat_t      b;
        d = (m && s == 8'h00) ? 8'h01 : s;
        if (len != 0 && cnt != 0) begin
            for (int f = 0; f < cnt; f++) begin
                for (int i = 0; i < len; i++) begin
                    b.d = d;
                    b.l = (i == len - 1);
                    b.f = (i == len - 1) && (f == cnt - 1);
                    exp_beats.push_back(b);
                    if (m) d = {1'b0, d[7:1]} ^ (d[0] ? 8'hB8 : 8'h00);
                    else   d = d + 8'd1;
                end
                if (f != cnt - 1) exp_gaps.push_back(gap);
            end
            exp_done.push_back(cnt);
        end else begin
            exp_done.push_back(0);
        end
    endtask

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            m_ready = ($urandom_range(99) < ready_pct);
        end
    end

    // Monitor: consumes expectations whenever the DUT shows a transfer, gap or done.
    initial begin
        bit         prev_stall = 0;
        bit         counting   = 0;
        bit         done_due   = 0;
        int         idle       = 0;
        logic [7:0] prev_data  = 0;
        logic       prev_last  = 0;
        beat_t      b;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                prev_stall = 0;
                counting   = 0;
                done_due   = 0;
            end else begin
                if (done_due) begin
                    chk("done_after_final", done, 1);
                    done_due = 0;
                end
                if (prev_stall) begin
                    chk("stall_valid", m_valid, 1);
                    chk("stall_data", m_data, prev_data);
                    chk("stall_last", m_last, prev_last);
                end
                if (counting) begin
                    if (m_valid) begin
                        counting = 0;
                        if (exp_gaps.size() == 0) bad("gap_unexpected");
                        else chk("gap_cycles", idle, exp_gaps.pop_front());
                    end else begin
                        idle++;
                    end
                end
                if (m_valid && m_ready) begin
                    xfer_cnt++;
                    if (exp_beats.size() == 0) begin
                        bad("beat_unexpected");
                    end else begin
                        b = exp_beats.pop_front();
                        chk("beat_data", m_data, b.d);
                        chk("beat_last", m_last, b.l);
                        if (b.l && !b.f) begin
                            counting = 1;
                            idle     = 0;
                        end
                        if (b.f) done_due = 1;
                    end
                end
                if (done) begin
                    if (exp_done.size() == 0) bad("done_unexpected");
                    else chk("frames_sent_at_done", frames_sent, exp_done.pop_front());
                    chk("busy_at_done", busy, 0);
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
            end
        end
    end

    task automatic run(input bit m, input logic [7:0] s, input int len, input int cnt,
                       input int gap, input int rp, input bit inject);
        bit got = 0;
        bit zero_case;
        zero_case = (len == 0 || cnt == 0);
        ready_pct = rp;
        model_push(m, s, len, cnt, gap);
        @(posedge clk_i);
        #1;
        start = 1'b1;
        mode = m;
        seed = s;
        frame_len = 16'(len);
        frame_cnt = 16'(cnt);
        gap_len = 8'(gap);
        @(posedge clk_i);
        #1;
        start = 1'b0;
        for (int n = 0; n < 5000; n++) begin
            @(negedge clk_i);
            if (n == 0) begin
                if (zero_case) begin
                    chk("zero_done", done, 1);
                    chk("zero_valid", m_valid, 0);
                end else begin
                    chk("start_busy", busy, 1);
                    chk("start_valid", m_valid, 1);
                end
            end
            if (done) begin
                got = 1;
                break;
            end
            if (inject && n == 3) begin
                start = 1'b1;
                seed = 8'hAA;
                frame_cnt = 16'd7;
            end
            if (inject && n == 4) start = 1'b0;
        end
        if (!got) bad("done_timeout");
        if (inject) begin
            start = 1'b1;
            @(posedge clk_i);
            #1;
            start = 1'b0;
            @(negedge clk_i);
            chk("start_in_done_ignored_valid", m_valid, 0);
            chk("start_in_done_ignored_busy", busy, 0);
        end
        chk("beats_drained", exp_beats.size(), 0);
        chk("gaps_drained", exp_gaps.size(), 0);
    endtask

    task automatic reset_mid_frame();
        int  base;
        bit  hit = 0;
        ready_pct = 100;
        model_push(1'b0, 8'h40, 10, 1, 0);
        base = xfer_cnt;
        @(posedge clk_i);
        #1;
        start = 1'b1;
        mode = 1'b0;
        seed = 8'h40;
        frame_len = 16'd10;
        frame_cnt = 16'd1;
        gap_len = 8'd0;
        @(posedge clk_i);
        #1;
        start = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (xfer_cnt - base >= 2) begin
                hit = 1;
                break;
            end
            @(posedge clk_i);
            #1;
        end
        if (!hit) bad("reset_wait_timeout");
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        exp_beats.delete();
        exp_gaps.delete();
        exp_done.delete();
        @(negedge clk_i);
        chk("rst_mid_valid", m_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_last", m_last, 0);
        chk("rst_mid_data", m_data, 0);
        chk("rst_mid_frames", frames_sent, 0);
        repeat (5) @(negedge clk_i);
        run(1'b0, 8'h40, 10, 1, 0, 100, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1;
        start = 1'b0;
        mode = 1'b0;
        seed = '0;
        frame_len = '0;
        frame_cnt = '0;
        gap_len = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_valid", m_valid, 0);
        chk("reset_data", m_data, 0);
        chk("reset_last", m_last, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_frames", frames_sent, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        run(1'b0, 8'h10, 4, 2, 0, 100, 0);
        run(1'b0, 8'h20, 3, 2, 5, 100, 0);
        run(1'b0, 8'h10, 4, 2, 0, 30, 0);
        run(1'b0, 8'h20, 3, 2, 5, 30, 0);
        run(1'b0, 8'hFE, 4, 1, 0, 100, 0);
        run(1'b1, 8'h00, 3, 2, 2, 60, 0);
        run(1'b0, 8'h33, 4, 0, 0, 100, 0);
        run(1'b0, 8'h33, 0, 3, 0, 100, 0);
        run(1'b0, 8'h50, 5, 3, 1, 100, 1);
        run(1'b1, 8'h77, 1, 3, 0, 50, 0);
        reset_mid_frame();
        for (int i = 0; i < 8; i++) begin
            run(1'($urandom_range(1)), 8'($urandom), $urandom_range(1, 6),
                $urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(30, 100), 0);
        end
        repeat (3) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
